// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode stage of a 16-bit in-order pipeline.
//               Holds the IF/ID pipeline register, splits the instruction
//               word into fields, reads two operands from an 8 x 16 register
//               file with write-through bypass from writeback, and detects
//               load-use hazards against the instruction in EX.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               if_*                - instruction word / PC+1 / valid from fetch
//               flush               - kill the instruction currently in ID
//               wb_en/addr/data     - register-file write port from writeback
//               ex_opcode/valid/rd  - instruction in EX, for hazard detection
//               stall_out           - freeze request to fetch
//               id_*                - decoded fields and operands toward EX
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter logic [3:0] LOAD_OP = 4'b0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc_plus1,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic [3:0]  ex_opcode,
    input  logic        ex_valid,
    input  logic [2:0]  ex_rd,
    output logic        stall_out,
    output logic        id_valid,
    output logic [3:0]  id_opcode,
    output logic [2:0]  id_rd,
    output logic [2:0]  id_rs1,
    output logic [2:0]  id_rs2,
    output logic [15:0] id_rs1_data,
    output logic [15:0] id_rs2_data,
    output logic [15:0] id_imm,
    output logic [15:0] id_pc_plus1
);

    localparam int c_NUM_REGS = 8;

    // IF/ID pipeline register
    logic [15:0] r_ir;
    logic [15:0] r_pc1;
    logic        r_v;

    // Register file; entry 0 is never written and is also masked on read
    logic [15:0] r_rf [c_NUM_REGS];

    logic [2:0]  w_rs1;
    logic [2:0]  w_rs2;
    logic        w_stall;
    logic [15:0] w_rs1_data;
    logic [15:0] w_rs2_data;

    assign w_rs1 = r_ir[8:6];
    assign w_rs2 = r_ir[5:3];

    // Conservative load-use check: both source fields are compared for every
    // opcode, even those that do not actually read rs2.
    assign w_stall = r_v & ex_valid & (ex_opcode == LOAD_OP) & (ex_rd != 3'd0) &
                     ((ex_rd == w_rs1) | (ex_rd == w_rs2));

    // IF/ID register: rst > flush > stall > load. Flush clears only the
    // valid bit and the instruction word; pc1 is left as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir  <= 16'h0000;
            r_pc1 <= 16'h0000;
            r_v   <= 1'b0;
        end else if (flush) begin
            r_ir  <= 16'h0000;
            r_v   <= 1'b0;
        end else if (!w_stall) begin
            r_ir  <= if_instr;
            r_pc1 <= if_pc_plus1;
            r_v   <= if_valid;
        end
    end

    // Register-file write port; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_rf[i] <= 16'h0000;
            end
        end else if (wb_en && (wb_addr != 3'd0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Operand reads with write-through bypass so an instruction in ID sees
    // the value being written back in the same cycle.
    always_comb begin
        w_rs1_data = 16'h0000;
        if (w_rs1 != 3'd0) begin
            if (wb_en && (wb_addr == w_rs1)) begin
                w_rs1_data = wb_data;
            end else begin
                w_rs1_data = r_rf[w_rs1];
            end
        end
    end

    always_comb begin
        w_rs2_data = 16'h0000;
        if (w_rs2 != 3'd0) begin
            if (wb_en && (wb_addr == w_rs2)) begin
                w_rs2_data = wb_data;
            end else begin
                w_rs2_data = r_rf[w_rs2];
            end
        end
    end

    assign stall_out   = w_stall;
    // A stalled instruction is presented as a bubble to EX
    assign id_valid    = r_v & ~w_stall;
    assign id_opcode   = r_ir[15:12];
    assign id_rd       = r_ir[11:9];
    assign id_rs1      = w_rs1;
    assign id_rs2      = w_rs2;
    assign id_imm      = {{10{r_ir[5]}}, r_ir[5:0]};
    assign id_pc_plus1 = r_pc1;
    assign id_rs1_data = w_rs1_data;
    assign id_rs2_data = w_rs2_data;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Each table row holds the
//               inputs driven for one cycle and the outputs expected during
//               that cycle (before its closing clock edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus1;
    logic        if_valid;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  ex_opcode;
    logic        ex_valid;
    logic [2:0]  ex_rd;
    logic        stall_out;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [2:0]  id_rd;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic [15:0] id_rs1_data;
    logic [15:0] id_rs2_data;
    logic [15:0] id_imm;
    logic [15:0] id_pc_plus1;

    int n_checks;
    int n_fail;

    decode_stage #(.LOAD_OP(4'b0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_instr    (if_instr),
        .if_pc_plus1 (if_pc_plus1),
        .if_valid    (if_valid),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_opcode   (ex_opcode),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .stall_out   (stall_out),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .id_imm      (id_imm),
        .id_pc_plus1 (id_pc_plus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic [15:0] if_instr;
        logic [15:0] if_pc;
        logic        if_valid;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        ex_valid;
        logic [3:0]  ex_op;
        logic [2:0]  ex_rd;
        logic        chk;
        logic        e_stall;
        logic        e_valid;
        logic [3:0]  e_op;
        logic [2:0]  e_rd;
        logic [2:0]  e_rs1;
        logic [2:0]  e_rs2;
        logic [15:0] e_imm;
        logic [15:0] e_pc;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
    } vec_t;

    localparam int c_NVEC = 15;
    vec_t vecs [c_NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rst;
        flush       = v.flush;
        if_instr    = v.if_instr;
        if_pc_plus1 = v.if_pc;
        if_valid    = v.if_valid;
        wb_en       = v.wb_en;
        wb_addr     = v.wb_addr;
        wb_data     = v.wb_data;
        ex_valid    = v.ex_valid;
        ex_opcode   = v.ex_op;
        ex_rd       = v.ex_rd;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; if_instr = 16'h0; if_pc_plus1 = 16'h0; if_valid = 1'b0;
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        ex_valid = 1'b0; ex_opcode = 4'h0; ex_rd = 3'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //           rst flush instr     pc       iv wb wa    wdata     ev op    erd   chk st vl op    rd    rs1   rs2   imm       pc        d1        d2
        vecs[0]  = '{1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0, 1'b0,1'b0,1'b0,4'h0,3'd0,3'd0,3'd0,16'h0000,16'h0000,16'h0000,16'h0000};
        vecs[1]  = '{1'b0,1'b0,16'h1A7F,16'h0005,1'b1,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b0,4'h0,3'd0,3'd0,3'd0,16'h0000,16'h0000,16'h0000,16'h0000};
        vecs[2]  = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b1,4'h1,3'd5,3'd1,3'd7,16'hFFFF,16'h0005,16'h0000,16'h0000};
        vecs[3]  = '{1'b0,1'b0,16'h20C0,16'h0010,1'b1,1'b1,3'd3,16'hBEEF,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b0,4'h0,3'd0,3'd0,3'd0,16'h0000,16'h0000,16'h0000,16'h0000};
        vecs[4]  = '{1'b0,1'b0,16'h3210,16'h0020,1'b1,1'b1,3'd0,16'h1234,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b1,4'h2,3'd0,3'd3,3'd0,16'h0000,16'h0010,16'hBEEF,16'h0000};
        vecs[5]  = '{1'b0,1'b0,16'h5508,16'h0030,1'b1,1'b1,3'd2,16'h00AA,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b1,4'h3,3'd1,3'd0,3'd2,16'h0010,16'h0020,16'h0000,16'h00AA};
        vecs[6]  = '{1'b0,1'b0,16'h6001,16'h0040,1'b1,1'b0,3'd0,16'h0000,1'b1,4'h4,3'd4, 1'b1,1'b1,1'b0,4'h5,3'd2,3'd4,3'd1,16'h0008,16'h0030,16'h0000,16'h0000};
        vecs[7]  = '{1'b0,1'b0,16'h6001,16'h0040,1'b1,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b1,4'h5,3'd2,3'd4,3'd1,16'h0008,16'h0030,16'h0000,16'h0000};
        vecs[8]  = '{1'b0,1'b0,16'h72A3,16'h0050,1'b1,1'b0,3'd0,16'h0000,1'b1,4'h4,3'd0, 1'b1,1'b0,1'b1,4'h6,3'd0,3'd0,3'd0,16'h0001,16'h0040,16'h0000,16'h0000};
        vecs[9]  = '{1'b0,1'b1,16'h1111,16'h0060,1'b1,1'b0,3'd0,16'h0000,1'b1,4'h4,3'd4, 1'b1,1'b1,1'b0,4'h7,3'd1,3'd2,3'd4,16'hFFE3,16'h0050,16'h00AA,16'h0000};
        vecs[10] = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000,1'b1,4'h4,3'd4, 1'b1,1'b0,1'b0,4'h0,3'd0,3'd0,3'd0,16'h0000,16'h0050,16'h0000,16'h0000};
        vecs[11] = '{1'b0,1'b0,16'h1A7F,16'h0005,1'b1,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b0,4'h0,3'd0,3'd0,3'd0,16'h0000,16'h0000,16'h0000,16'h0000};
        vecs[12] = '{1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b1,3'd3,16'hFFFF,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b1,4'h1,3'd5,3'd1,3'd7,16'hFFFF,16'h0005,16'h0000,16'h0000};
        vecs[13] = '{1'b0,1'b0,16'h00D0,16'h0070,1'b1,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b0,4'h0,3'd0,3'd0,3'd0,16'h0000,16'h0000,16'h0000,16'h0000};
        vecs[14] = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0, 1'b1,1'b0,1'b1,4'h0,3'd0,3'd3,3'd2,16'h0010,16'h0070,16'h0000,16'h0000};

        idle();
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d stall_out", i),   {15'd0, stall_out},   {15'd0, vecs[i].e_stall});
                check($sformatf("v%0d id_valid", i),    {15'd0, id_valid},    {15'd0, vecs[i].e_valid});
                check($sformatf("v%0d id_opcode", i),   {12'd0, id_opcode},   {12'd0, vecs[i].e_op});
                check($sformatf("v%0d id_rd", i),       {13'd0, id_rd},       {13'd0, vecs[i].e_rd});
                check($sformatf("v%0d id_rs1", i),      {13'd0, id_rs1},      {13'd0, vecs[i].e_rs1});
                check($sformatf("v%0d id_rs2", i),      {13'd0, id_rs2},      {13'd0, vecs[i].e_rs2});
                check($sformatf("v%0d id_imm", i),      id_imm,               vecs[i].e_imm);
                check($sformatf("v%0d id_pc_plus1", i), id_pc_plus1,          vecs[i].e_pc);
                check($sformatf("v%0d id_rs1_data", i), id_rs1_data,          vecs[i].e_d1);
                check($sformatf("v%0d id_rs2_data", i), id_rs2_data,          vecs[i].e_d2);
            end
        end

        // Bypass on r2 followed by a read of the stored value (fetch word held)
        @(negedge clk);
        idle();
        if_instr = 16'h0080; if_pc_plus1 = 16'h0080; if_valid = 1'b1;
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h5555;
        #1;
        check("seqA bypass rs1_data", id_rs1_data, 16'h5555);
        check("seqA rs1 field", {13'd0, id_rs1}, 16'd2);
        @(negedge clk);
        wb_en = 1'b0; wb_data = 16'h0000;
        #1;
        check("seqA stored rs1_data", id_rs1_data, 16'h5555);

        // Reset wins over a simultaneous flush and an active stall
        ex_valid = 1'b1; ex_opcode = 4'b0100; ex_rd = 3'd2;
        #1;
        check("seqB stall before rst", {15'd0, stall_out}, 16'd1);
        check("seqB id_valid before rst", {15'd0, id_valid}, 16'd0);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        #1;
        check("seqB stall after rst", {15'd0, stall_out}, 16'd0);
        check("seqB id_valid after rst", {15'd0, id_valid}, 16'd0);
        check("seqB pc after rst", id_pc_plus1, 16'h0000);
        check("seqB opcode after rst", {12'd0, id_opcode}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: LOAD_OP, default 4'b0100, opcode value that identifies a load instruction in EX.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 if_instr  input  16  instruction word from fetch.
REQ-005 if_pc_plus1  input  16  PC+1 from fetch.
REQ-006 if_valid  input  1  fetch output valid.
REQ-007 flush  input  1  branch-redirect kill of the instruction in ID.
REQ-008 wb_en  input  1  register-file write enable from writeback.
REQ-009 wb_addr  input  3  writeback register index.
REQ-010 wb_data  input  16  writeback data.
REQ-011 ex_opcode  input  4  opcode of the instruction currently in EX.
REQ-012 ex_valid  input  1  EX instruction valid.
REQ-013 ex_rd  input  3  destination register of the EX instruction.
REQ-014 stall_out  output  1  hold request to fetch (PC and fetch outputs frozen).
REQ-015 id_valid  output  1  decoded instruction valid toward EX.
REQ-016 id_opcode  output  4  instruction bits [15:12].
REQ-017 id_rd / id_rs1 / id_rs2  output  3 each  bits [11:9] / [8:6] / [5:3].
REQ-018 id_rs1_data / id_rs2_data  output  16 each  register operands.
REQ-019 id_imm  output  16  bits [5:0], sign-extended to 16 bits.
REQ-020 id_pc_plus1  output  16  registered PC+1.

Function
REQ-021 IF/ID register contents: ir (16), pc1 (16), v (1); it SHALL update on the rising edge of clk.
REQ-022 Update priority SHALL be rst > flush > stall_out > load: flush sets v=0 and ir=16'h0000; stall_out holds all fields; load captures if_instr, if_pc_plus1 and if_valid.
REQ-023 Latency: a word presented on if_* before edge N SHALL appear on id_* after edge N (1 cycle).
REQ-024 id_opcode, id_rd, id_rs1, id_rs2, id_imm and id_pc_plus1 SHALL be combinational decodes of ir and pc1.
REQ-025 Register file: 8 x 16 bits. r0 SHALL read as 0. A write to r0 SHALL be discarded.
REQ-026 Write: when wb_en=1 and wb_addr!=0, the entry SHALL update on the rising clk edge.
REQ-027 Reads SHALL be combinational with write-through bypass: if wb_en=1, wb_addr==rsX and rsX!=0, then id_rsX_data=wb_data in that same cycle.
REQ-028 stall_out SHALL equal v & ex_valid & (ex_opcode==LOAD_OP) & (ex_rd!=0) & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
- The comparison is conservative: both source fields are compared for every opcode.
REQ-029 id_valid SHALL equal v & ~stall_out, so that EX receives a bubble for each stall cycle.
REQ-030 flush and stall asserted together: flush wins, the ID slot becomes invalid, and stall_out drops in the following cycle.
REQ-031 A stall SHALL last exactly one cycle per load-use pair, because the load leaves EX.
REQ-032 No arithmetic is performed other than sign extension; pc1 is carried unmodified, with no wrap handling needed.

Reset
REQ-033 With rst=1 at an edge: v=0, ir=16'h0000, pc1=16'h0000, and all 8 register entries=16'h0000.
REQ-034 After reset: id_valid=0, stall_out=0, id_opcode=0, id_imm=0, and operand data=0.
REQ-035 rst SHALL override flush, stall and wb_en in the same cycle; a write pending with rst is discarded.
REQ-036 Reset asserted mid-stream SHALL discard the in-flight ID instruction.

Verification
REQ-037 Decode/latency: if_instr=16'h1A7F, if_valid=1, pc+1=16'h0005 -> after one edge: id_opcode=1, id_rd=5, id_rs1=1, id_rs2=7, id_imm=16'hFFFF, id_pc_plus1=5, id_valid=1.
REQ-038 Register file and r0:
- Write r3=16'hBEEF, then decode rs1=3 -> id_rs1_data=BEEF.
- Write r0=16'h1234, then read rs1=0 -> 0.
REQ-039 Bypass: wb_en=1, wb_addr=2, wb_data=16'h00AA in the same cycle ID reads rs2=2 -> id_rs2_data=00AA combinationally.
REQ-040 Load-use: ex_valid=1, ex_opcode=LOAD_OP, ex_rd=4, ID rs1=4 -> stall_out=1 and id_valid=0 for 1 cycle with ID contents held; with ex_rd=0 instead -> no stall.
REQ-041 Flush vs stall: flush=1 during an active stall -> next cycle v=0, ir=0, stall_out=0.
REQ-042 Reset mid-stream: rst=1 with valid ID and wb_en=1 -> all outputs 0, the write is dropped, and register reads return 0.
